// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with MemReady handshake and memory-timeout abort.
// Build option: define MULTICYCLE_CONTROL_JAL_EN to decode OpCode 0x03 as jal.
module multicycle_control #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OpCode,
   input  logic [5:0] funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic [1:0] RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       Fault,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTYPE  = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_JAL    = 4'd12
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fault_q, fault_d;
   logic             abort_q, abort_d;
   logic             wait_st;
   logic             timeout;

   // funct goes straight to ALU control and Zero qualifies PCWriteCond in the datapath.
   logic unused_ok;
   assign unused_ok = ^{funct, Zero};

   // abort_q marks the first FETCH after a timeout: the request stays dropped for that cycle.
   assign wait_st = (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) && !abort_q;
   assign timeout = wait_st && !MemReady && (cnt_q == CNT_MAX);

   always_comb begin
      state_d = state_q;
      fault_d = 1'b0;
      abort_d = 1'b0;
      case (state_q)
         S_FETCH:  if (!abort_q && MemReady) state_d = S_DECODE;
         S_DECODE: begin
            case (OpCode)
               6'h00:        state_d = S_RTYPE;
               6'h23, 6'h2B: state_d = S_MEMADR;
               6'h04:        state_d = S_BRANCH;
               6'h08:        state_d = S_ADDIEX;
               6'h02, 6'h1A: state_d = S_JUMP;
`ifdef MULTICYCLE_CONTROL_JAL_EN
               6'h03:        state_d = S_JAL;
`endif
               default: begin
                  state_d = S_FETCH;
                  fault_d = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_d = (OpCode == 6'h2B) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (MemReady) state_d = S_MEMWB;
         S_MEMWR:  if (MemReady) state_d = S_FETCH;
         S_RTYPE:  state_d = S_RWB;
         S_ADDIEX: state_d = S_ADDIWB;
         default:  state_d = S_FETCH;
      endcase
      if (timeout) begin
         state_d = S_FETCH;
         fault_d = 1'b1;
         abort_d = 1'b1;
      end
   end

   always_comb begin
      if (!wait_st || timeout || state_d != state_q) begin
         cnt_d = '0;
      end else if (!MemReady && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         fault_q <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
         abort_q <= abort_d;
      end
   end

   // Outputs are forced low while reset is high so no enable escapes mid-instruction.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 2'd0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'd0;
      ALUOp       = 2'd0;
      PCSource    = 2'd0;
      Fault       = 1'b0;
      State       = 4'd0;
      if (!reset) begin
         State = state_q;
         Fault = fault_q;
         case (state_q)
            S_FETCH: begin
               MemRead = !abort_q;
               ALUSrcB = 2'd1;
               IRWrite = MemReady && !abort_q;
               PCWrite = MemReady && !abort_q;
            end
            S_DECODE: ALUSrcB = 2'd3;
            S_MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'd2;
            end
            S_MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEMWB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            S_MEMWR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            S_RTYPE: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'd2;
            end
            S_RWB: begin
               RegWrite = 1'b1;
               RegDst   = 2'd1;
            end
            S_BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = 2'd1;
               PCWriteCond = 1'b1;
               PCSource    = 2'd1;
            end
            S_ADDIEX: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'd2;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
               PCWrite  = 1'b1;
               PCSource = 2'd2;
            end
`ifdef MULTICYCLE_CONTROL_JAL_EN
            S_JAL: begin
               PCWrite  = 1'b1;
               PCSource = 2'd2;
               RegWrite = 1'b1;
               RegDst   = 2'd2;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; each step queues the expected output vector
// and the cycle's negedge pops and compares it. Honours MULTICYCLE_CONTROL_JAL_EN.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] OpCode, funct;
   logic       Zero, MemReady;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
   logic [1:0] RegDst, ALUSrcB, ALUOp, PCSource;
   logic       RegWrite, ALUSrcA, Fault;
   logic [3:0] State;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, pcwc, iord, mrd, mwr, irw, m2r;
      logic [1:0] rdst;
      logic       rw, srca;
      logic [1:0] srcb, aluop, pcsrc;
      logic       flt;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    checks = 0;
   int    passed = 0;

   multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .OpCode(OpCode), .funct(funct), .Zero(Zero),
      .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .Fault(Fault), .State(State)
   );

   always #5 clk = ~clk;

   // Expected outputs per state, straight from the control table.
   function automatic exp_t ex(input logic [3:0] st, input logic rdy, input logic flt,
                               input logic abrt);
      exp_t e;
      e     = '0;
      e.st  = st;
      e.flt = flt;
      case (st)
         4'd0:  begin e.mrd = !abrt; e.srcb = 2'd1; e.irw = rdy && !abrt; e.pcw = rdy && !abrt; end
         4'd1:  e.srcb = 2'd3;
         4'd2:  begin e.srca = 1'b1; e.srcb = 2'd2; end
         4'd3:  begin e.mrd = 1'b1; e.iord = 1'b1; end
         4'd4:  begin e.rw = 1'b1; e.m2r = 1'b1; end
         4'd5:  begin e.mwr = 1'b1; e.iord = 1'b1; end
         4'd6:  begin e.srca = 1'b1; e.aluop = 2'd2; end
         4'd7:  begin e.rw = 1'b1; e.rdst = 2'd1; end
         4'd8:  begin e.srca = 1'b1; e.aluop = 2'd1; e.pcwc = 1'b1; e.pcsrc = 2'd1; end
         4'd9:  begin e.srca = 1'b1; e.srcb = 2'd2; end
         4'd10: e.rw = 1'b1;
         4'd11: begin e.pcw = 1'b1; e.pcsrc = 2'd2; end
         4'd12: begin e.pcw = 1'b1; e.pcsrc = 2'd2; e.rw = 1'b1; e.rdst = 2'd2; end
         default: ;
      endcase
      return e;
   endfunction

   function automatic exp_t S(input logic [3:0] st);
      return ex(st, 1'b0, 1'b0, 1'b0);
   endfunction

   task automatic step(input string tag, input logic rst, input logic [5:0] op,
                       input logic rdy, input logic z, input exp_t e);
      exp_t got, want;
      string t;
      reset    = rst;
      OpCode   = op;
      MemReady = rdy;
      Zero     = z;
      funct    = 6'($urandom);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      got  = {State, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
              RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Fault};
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      checks++;
      assert (got === want) passed++;
      else $error("FAIL %s: observed %h required %h", t, got, want);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset, then R-type: 0,1,6,7,0
      for (int i = 0; i < 3; i++) step("reset", 1'b1, 6'h00, 1'b1, 1'b0, '0);
      step("r_fetch",  1'b0, 6'h00, 1'b1, 1'b0, ex(4'd0, 1'b1, 1'b0, 1'b0));
      step("r_decode", 1'b0, 6'h00, 1'b0, 1'b0, S(4'd1));
      step("r_exec",   1'b0, 6'h00, 1'b1, 1'b0, S(4'd6));
      step("r_wb",     1'b0, 6'h00, 1'b0, 1'b0, S(4'd7));

      // lw with four wait cycles
      step("lw_fetch",  1'b0, 6'h23, 1'b1, 1'b0, ex(4'd0, 1'b1, 1'b0, 1'b0));
      step("lw_decode", 1'b0, 6'h23, 1'b0, 1'b0, S(4'd1));
      step("lw_adr",    1'b0, 6'h23, 1'b1, 1'b0, S(4'd2));
      for (int i = 0; i < 4; i++) step("lw_wait", 1'b0, 6'h23, 1'b0, 1'b0, S(4'd3));
      step("lw_rd_done", 1'b0, 6'h23, 1'b1, 1'b0, S(4'd3));
      step("lw_wb",      1'b0, 6'h23, 1'b0, 1'b0, S(4'd4));

      // sw that never completes: 16 cycles in MEMWR, then aborted fetch with Fault
      step("sw_fetch",  1'b0, 6'h2B, 1'b1, 1'b0, ex(4'd0, 1'b1, 1'b0, 1'b0));
      step("sw_decode", 1'b0, 6'h2B, 1'b0, 1'b0, S(4'd1));
      step("sw_adr",    1'b0, 6'h2B, 1'b0, 1'b0, S(4'd2));
      for (int i = 0; i < 16; i++) step("sw_wait", 1'b0, 6'h2B, 1'b0, 1'b0, S(4'd5));
      step("sw_abort", 1'b0, 6'h2B, 1'b1, 1'b0, ex(4'd0, 1'b1, 1'b1, 1'b1));

      // beq with Zero=1 then Zero=0
      for (int z = 1; z >= 0; z--) begin
         step("beq_fetch",  1'b0, 6'h04, 1'b1, 1'(z), ex(4'd0, 1'b1, 1'b0, 1'b0));
         step("beq_decode", 1'b0, 6'h04, 1'b0, 1'(z), S(4'd1));
         step("beq_branch", 1'b0, 6'h04, 1'b1, 1'(z), S(4'd8));
      end

      // illegal opcode, then jump via 0x1A
      step("ill_fetch",  1'b0, 6'h3F, 1'b1, 1'b0, ex(4'd0, 1'b1, 1'b0, 1'b0));
      step("ill_decode", 1'b0, 6'h3F, 1'b0, 1'b0, S(4'd1));
      step("ill_fault",  1'b0, 6'h1A, 1'b1, 1'b0, ex(4'd0, 1'b1, 1'b1, 1'b0));
      step("j_decode",   1'b0, 6'h1A, 1'b0, 1'b0, S(4'd1));
      step("j_jump",     1'b0, 6'h1A, 1'b0, 1'b0, S(4'd11));

      // addi
      step("addi_fetch",  1'b0, 6'h08, 1'b1, 1'b0, ex(4'd0, 1'b1, 1'b0, 1'b0));
      step("addi_decode", 1'b0, 6'h08, 1'b0, 1'b0, S(4'd1));
      step("addi_ex",     1'b0, 6'h08, 1'b0, 1'b0, S(4'd9));
      step("addi_wb",     1'b0, 6'h08, 1'b1, 1'b0, S(4'd10));

      // jal: legal only with the feature enabled
      step("jal_fetch",  1'b0, 6'h03, 1'b1, 1'b0, ex(4'd0, 1'b1, 1'b0, 1'b0));
      step("jal_decode", 1'b0, 6'h03, 1'b0, 1'b0, S(4'd1));
`ifdef MULTICYCLE_CONTROL_JAL_EN
      step("jal_exec",   1'b0, 6'h03, 1'b0, 1'b0, S(4'd12));
      step("jal_done",   1'b0, 6'h00, 1'b0, 1'b0, S(4'd0));
`else
      step("jal_fault",  1'b0, 6'h00, 1'b0, 1'b0, ex(4'd0, 1'b0, 1'b1, 1'b0));
`endif

      // MemReady arriving on the saturation cycle completes the read without a fault
      step("sat_fetch",  1'b0, 6'h23, 1'b1, 1'b0, ex(4'd0, 1'b1, 1'b0, 1'b0));
      step("sat_decode", 1'b0, 6'h23, 1'b0, 1'b0, S(4'd1));
      step("sat_adr",    1'b0, 6'h23, 1'b0, 1'b0, S(4'd2));
      for (int i = 0; i < 15; i++) step("sat_wait", 1'b0, 6'h23, 1'b0, 1'b0, S(4'd3));
      step("sat_ready", 1'b0, 6'h23, 1'b1, 1'b0, S(4'd3));
      step("sat_wb",    1'b0, 6'h23, 1'b0, 1'b0, S(4'd4));

      // fetch timeout re-enters FETCH with a cleared counter
      for (int i = 0; i < 16; i++) step("ft_wait", 1'b0, 6'h00, 1'b0, 1'b0, S(4'd0));
      step("ft_abort", 1'b0, 6'h00, 1'b0, 1'b0, ex(4'd0, 1'b0, 1'b1, 1'b1));
      for (int i = 0; i < 15; i++) step("ft_rewait", 1'b0, 6'h00, 1'b0, 1'b0, S(4'd0));
      step("ft_ready", 1'b0, 6'h00, 1'b1, 1'b0, ex(4'd0, 1'b1, 1'b0, 1'b0));

      // reset in RWB suppresses the register write and restarts at FETCH
      step("mr_decode", 1'b0, 6'h00, 1'b0, 1'b0, S(4'd1));
      step("mr_exec",   1'b0, 6'h00, 1'b0, 1'b0, S(4'd6));
      step("mr_reset",  1'b1, 6'h00, 1'b1, 1'b0, '0);
      step("mr_fetch",  1'b0, 6'h00, 1'b0, 1'b0, S(4'd0));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
